// File: rtl/f_pc_unit_pkg.sv
// Shared constants for the fetch-stage PC unit: reset/exception vectors,
// instruction-memory window, exception codes and next-PC select encodings.
package f_pc_unit_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    NPC_PC4 = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // Misaligned or outside the instruction-memory window.
  function automatic logic pc_is_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

endpackage

// File: rtl/f_pc_unit_if.sv
// Redirect/control inputs and fetch-state outputs of the PC unit.
// slave = PC unit, master = the surrounding pipeline (or a bench).
interface f_pc_unit_if;

  logic        F_PC_EN;
  logic        Req;
  logic        eret;
  logic [31:0] EPC;
  logic [1:0]  D_NPC_sel;
  logic [31:0] D_target;
  logic        D_is_jb;

  logic [31:0] F_PC;
  logic        F_BD;
  logic [4:0]  F_ExcCode;
  logic [31:0] F_fetch_cnt;

  modport slave (
    input  F_PC_EN, Req, eret, EPC, D_NPC_sel, D_target, D_is_jb,
    output F_PC, F_BD, F_ExcCode, F_fetch_cnt
  );

  modport master (
    output F_PC_EN, Req, eret, EPC, D_NPC_sel, D_target, D_is_jb,
    input  F_PC, F_BD, F_ExcCode, F_fetch_cnt
  );

endinterface

// File: rtl/f_pc_unit_npc_sel.sv
// Next-PC mux, purely combinational: Req > eret > stall > D_NPC_sel.
// load flags every cycle where the PC register takes a new value; no backpressure.
module f_pc_unit_npc_sel
  import f_pc_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        eret,
  input  logic        en,
  input  logic [31:0] epc,
  input  logic [1:0]  sel,
  input  logic [31:0] target,
  output logic [31:0] npc,
  output logic        load
);

  always_comb begin
    npc  = pc;
    load = 1'b0;
    if (req) begin
      npc  = EXC_ENTRY;
      load = 1'b1;
    end else if (eret) begin
      npc  = epc;
      load = 1'b1;
    end else if (en) begin
      load = 1'b1;
      // Branch, jump-imm and jump-reg all arrive pre-resolved as D_target.
      npc  = (sel == NPC_PC4) ? pc + 32'd4 : target;
    end
  end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch PC register, advance counter and fetch address-error check; redirects take
// effect one edge after sampling. F_PC_EN=0 stalls, but Req/eret always redirect.
module f_pc_unit
  import f_pc_unit_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  f_pc_unit_if.slave    pc_if
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] npc;
  logic        load;

  f_pc_unit_npc_sel u_npc_sel (
    .pc     (pc_q),
    .req    (pc_if.Req),
    .eret   (pc_if.eret),
    .en     (pc_if.F_PC_EN),
    .epc    (pc_if.EPC),
    .sel    (pc_if.D_NPC_sel),
    .target (pc_if.D_target),
    .npc    (npc),
    .load   (load)
  );

  always_comb begin
    pc_d        = npc;
    fetch_cnt_d = load ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= PC_RESET;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // A bad PC is only flagged here; CP0 flushes it by raising Req.
  assign pc_if.F_PC        = pc_q;
  assign pc_if.F_fetch_cnt = fetch_cnt_q;
  assign pc_if.F_ExcCode   = pc_is_adel(pc_q) ? EXC_ADEL : EXC_NONE;
  assign pc_if.F_BD        = pc_if.D_is_jb & ~pc_if.Req & ~pc_if.eret;

endmodule

// File: tb/tb_f_pc_unit.sv
// Directed-vector bench for f_pc_unit: stimulus pushes hand-computed expectations,
// an independent monitor pops and compares one entry after each clock edge.
module tb_f_pc_unit;

  logic clk;
  logic reset;

  f_pc_unit_if pc_if ();

  f_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .pc_if (pc_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_id = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the state
  // expected just after the following rising edge.
  task automatic step(input logic en, input logic rq, input logic er,
                      input logic [31:0] epc, input logic [1:0] sel,
                      input logic [31:0] tgt, input logic jb,
                      input logic [31:0] e_pc, input logic e_bd,
                      input logic [4:0] e_exc, input logic [31:0] e_cnt);
    exp_t e;
    @(negedge clk);
    pc_if.F_PC_EN   = en;
    pc_if.Req       = rq;
    pc_if.eret      = er;
    pc_if.EPC       = epc;
    pc_if.D_NPC_sel = sel;
    pc_if.D_target  = tgt;
    pc_if.D_is_jb   = jb;
    vec_id++;
    e.id  = vec_id;
    e.pc  = e_pc;
    e.bd  = e_bd;
    e.exc = e_exc;
    e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per edge, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp($sformatf("v%0d F_PC", e.id),        pc_if.F_PC,                e.pc);
      cmp($sformatf("v%0d F_BD", e.id),        {31'd0, pc_if.F_BD},       {31'd0, e.bd});
      cmp($sformatf("v%0d F_ExcCode", e.id),   {27'd0, pc_if.F_ExcCode},  {27'd0, e.exc});
      cmp($sformatf("v%0d F_fetch_cnt", e.id), pc_if.F_fetch_cnt,         e.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    pc_if.F_PC_EN   = 1'b0;
    pc_if.Req       = 1'b0;
    pc_if.eret      = 1'b0;
    pc_if.EPC       = 32'd0;
    pc_if.D_NPC_sel = 2'b00;
    pc_if.D_target  = 32'd0;
    pc_if.D_is_jb   = 1'b1;

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("rst F_PC",        pc_if.F_PC,                 32'h0000_3000);
    cmp("rst F_fetch_cnt", pc_if.F_fetch_cnt,          32'd0);
    cmp("rst F_ExcCode",   {27'd0, pc_if.F_ExcCode},   32'd0);
    cmp("rst F_BD jb",     {31'd0, pc_if.F_BD},        32'd1);
    pc_if.Req = 1'b1;
    #1;
    cmp("rst F_BD req",    {31'd0, pc_if.F_BD},        32'd0);
    pc_if.Req = 1'b0;
    @(posedge clk);
    #1;
    cmp("rst hold F_PC",   pc_if.F_PC,                 32'h0000_3000);
    @(negedge clk);
    reset = 1'b0;

    //    en  rq  er  epc           sel    tgt           jb    pc            bd    exc   cnt
    step(0, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_3000, 0, 5'd0, 32'd0);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_3004, 0, 5'd0, 32'd1);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_3008, 0, 5'd0, 32'd2);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_300C, 0, 5'd0, 32'd3);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_3010, 0, 5'd0, 32'd4);
    // Stall with a taken branch pending, then release it.
    step(0, 0, 0, 32'h0,        2'b01, 32'h3100,     0,    32'h0000_3010, 0, 5'd0, 32'd4);
    step(0, 0, 0, 32'h0,        2'b01, 32'h3100,     0,    32'h0000_3010, 0, 5'd0, 32'd4);
    step(1, 0, 0, 32'h0,        2'b01, 32'h3100,     1,    32'h0000_3100, 1, 5'd0, 32'd5);
    // Req and eret together while stalled: Req wins, BD forced low.
    step(0, 1, 1, 32'h3200,     2'b00, 32'h0,        1,    32'h0000_4180, 0, 5'd0, 32'd6);
    // eret to a misaligned EPC, then the exception flush.
    step(0, 0, 1, 32'h3202,     2'b00, 32'h0,        0,    32'h0000_3202, 0, 5'd4, 32'd7);
    step(0, 1, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_4180, 0, 5'd0, 32'd8);
    // Window boundaries via jump-reg / jump-imm / branch / PC+4.
    step(1, 0, 0, 32'h0,        2'b11, 32'h7000,     1,    32'h0000_7000, 1, 5'd4, 32'd9);
    step(1, 0, 0, 32'h0,        2'b10, 32'h6FFC,     0,    32'h0000_6FFC, 0, 5'd0, 32'd10);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_7000, 0, 5'd4, 32'd11);
    step(1, 0, 0, 32'h0,        2'b01, 32'h2FFC,     0,    32'h0000_2FFC, 0, 5'd4, 32'd12);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_3000, 0, 5'd0, 32'd13);
    // PC+4 wraps modulo 2^32.
    step(0, 0, 1, 32'hFFFF_FFFC, 2'b00, 32'h0,       1,    32'hFFFF_FFFC, 0, 5'd4, 32'd14);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_0000, 0, 5'd4, 32'd15);
    step(0, 0, 1, 32'h5000,     2'b00, 32'h0,        1,    32'h0000_5000, 0, 5'd0, 32'd16);

    // Preload the counter to its maximum during a stall, then advance once.
    @(negedge clk);
    force dut.fetch_cnt_d = 32'hFFFF_FFFF;
    step(0, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_5000, 0, 5'd0, 32'hFFFF_FFFF);
    @(posedge clk);
    #2;
    release dut.fetch_cnt_d;
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_5004, 0, 5'd0, 32'd0);
    step(1, 0, 0, 32'h0,        2'b00, 32'h0,        0,    32'h0000_5008, 0, 5'd0, 32'd1);

    repeat (3) @(posedge clk);
    #2;
    cmp("scoreboard drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
